// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: initiator for the register file en/register_done handshake.
// It accepts operand-read and writeback requests from the control path, runs one
// register file access for them, returns the operands and acks, and then waits for
// the register file to drop done before it accepts the next request. A register
// file that never answers is aborted after TIMEOUT_CYCLES and flagged in timeout_err.
// Optional feature: define REGFILE_BYPASS_EN to forward wb_data into the operands
// when a combined access reads the register it writes.
module regfile_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [4:0]  rd_rs,
   input  logic [4:0]  rd_rt,
   input  logic        wb_req,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        ready,
   output logic        rd_ack,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic        wb_ack,
   output logic        timeout_err,
   output logic        rf_en,
   output logic        rf_reg_write,
   output logic [4:0]  rf_read_reg1,
   output logic [4:0]  rf_read_reg2,
   output logic [4:0]  rf_write_reg,
   output logic [31:0] rf_write_data,
   input  logic [31:0] rf_read_data1,
   input  logic [31:0] rf_read_data2,
   input  logic        rf_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   // Count value of the last ACCESS cycle allowed before the access is abandoned.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic        rd_pend;
   logic        wb_pend;
   logic [31:0] rs_next;
   logic [31:0] rt_next;

   // Operands to capture on done: the register file's read data, or the value being
   // written when the bypass is built in and a read source matches the destination.
   always_comb begin
      rs_next = rf_read_data1;
      rt_next = rf_read_data2;
`ifdef REGFILE_BYPASS_EN
      if (wb_pend && (rf_write_reg != 5'd0)) begin
         if (rf_read_reg1 == rf_write_reg) rs_next = rf_write_data;
         if (rf_read_reg2 == rf_write_reg) rt_next = rf_write_data;
      end
`endif
   end

   // Handshake sequencer: every output is a register so the register file sees clean levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         rd_pend       <= 1'b0;
         wb_pend       <= 1'b0;
         ready         <= 1'b1;
         rd_ack        <= 1'b0;
         wb_ack        <= 1'b0;
         rs_data       <= 32'd0;
         rt_data       <= 32'd0;
         timeout_err   <= 1'b0;
         rf_en         <= 1'b0;
         rf_reg_write  <= 1'b0;
         rf_read_reg1  <= 5'd0;
         rf_read_reg2  <= 5'd0;
         rf_write_reg  <= 5'd0;
         rf_write_data <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               rd_ack <= 1'b0;
               wb_ack <= 1'b0;
               if (rd_req || wb_req) begin
                  // A simultaneous read and writeback share one access.
                  state         <= ACCESS;
                  ready         <= 1'b0;
                  rf_en         <= 1'b1;
                  cnt           <= 8'd0;
                  rd_pend       <= rd_req;
                  wb_pend       <= wb_req;
                  rf_reg_write  <= wb_req && (wb_rd != 5'd0);
                  rf_read_reg1  <= rd_req ? rd_rs : 5'd0;
                  rf_read_reg2  <= rd_req ? rd_rt : 5'd0;
                  rf_write_reg  <= wb_req ? wb_rd : 5'd0;
                  rf_write_data <= wb_req ? wb_data : 32'd0;
               end
            end
            ACCESS: begin
               if (rf_done) begin
                  if (rd_pend) begin
                     rs_data <= rs_next;
                     rt_data <= rt_next;
                  end
                  rd_ack       <= rd_pend;
                  wb_ack       <= wb_pend;
                  rf_en        <= 1'b0;
                  rf_reg_write <= 1'b0;
                  state        <= RECOVER;
               end else if (cnt == LAST_CNT) begin
                  // Hung register file: release the requester with zero operands.
                  timeout_err  <= 1'b1;
                  if (rd_pend) begin
                     rs_data <= 32'd0;
                     rt_data <= 32'd0;
                  end
                  rd_ack       <= rd_pend;
                  wb_ack       <= wb_pend;
                  rf_en        <= 1'b0;
                  rf_reg_write <= 1'b0;
                  state        <= RECOVER;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RECOVER: begin
               // A done still high from this access must not be mistaken for the next one.
               rd_ack <= 1'b0;
               wb_ack <= 1'b0;
               if (!rf_done) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               rf_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
